clkdiv_ctrl: RTL and testbench

Run-time programmable clock-divider controller. It generates a divided clock-enable waveform from the system clock and accepts new divisors over a valid/ready handshake. New divisors are applied only at period boundaries, so `clk_out` never produces a runt phase. Sits between configuration logic (CPU/UART register file) and fabric consumers that need a retunable slow clock or strobe.

---
 rtl/clkdiv_pkg.sv | 28 ++
 rtl/clkdiv_core.sv | 66 ++++++
 rtl/clkdiv_ctrl.sv | 117 +++++++++++
 tb/tb_clkdiv_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock-divider controller.
// Optional tick strobe is enabled by defining CLKDIV_TICK_EN.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUN     = 2'd1,
    PEND    = 2'd2
  } clkdiv_state_t;

  localparam int unsigned DIV_MIN = 2;

  // Reset divisor: integer ratio of the two frequencies, never below DIV_MIN.
  function automatic int unsigned clkdiv_default(input int unsigned clk_freq,
                                                 input int unsigned out_freq);
    int unsigned div;
    if (out_freq == 0) begin
      div = DIV_MIN;
    end else begin
      div = clk_freq / out_freq;
    end
    if (div < DIV_MIN) begin
      div = DIV_MIN;
    end
    return div;
  endfunction

endpackage

// File: rtl/clkdiv_core.sv
// Loadable down-counter with reload and registered clk_out compare.
// The tick strobe output exists only when CLKDIV_TICK_EN is defined.
module clkdiv_core
  import clkdiv_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter logic [DIV_W-1:0] RESET_DIV = DIV_W'(2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             counting,
  input  logic             run_next,
  input  logic [DIV_W-1:0] div_next,
  output logic             wrap,
  output logic             clk_out
`ifdef CLKDIV_TICK_EN
  ,
  output logic             tick
`endif
);

  logic [DIV_W-1:0] counter_q, counter_d;
  logic             clk_out_q, clk_out_d;

  assign wrap    = counting && (counter_q == '0);
  assign clk_out = clk_out_q;

  // While stopped the counter tracks the (possibly just loaded) divisor so the
  // first running edge starts a full high phase.
  always_comb begin
    counter_d = counter_q - DIV_W'(1);
    if (!counting || (counter_q == '0)) begin
      counter_d = div_next - DIV_W'(1);
    end
    clk_out_d = run_next && (counter_d >= (div_next >> 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q <= RESET_DIV - DIV_W'(1);
      clk_out_q <= 1'b0;
    end else begin
      counter_q <= counter_d;
      clk_out_q <= clk_out_d;
    end
  end

`ifdef CLKDIV_TICK_EN
  logic tick_q, tick_d;

  assign tick = tick_q;

  always_comb begin
    tick_d = run_next && (counter_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end
`endif

endmodule

// File: rtl/clkdiv_ctrl.sv
// Run-time programmable clock divider: FSM, divisor handshake and clamp.
// Define CLKDIV_TICK_EN to add the one-cycle-per-period tick output.
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 12_000_000,
  parameter int unsigned DEFAULT_FREQ = 6_000_000,
  parameter int          DIV_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             active
`ifdef CLKDIV_TICK_EN
  ,
  output logic             tick
`endif
);

  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(clkdiv_default(CLK_FREQ, DEFAULT_FREQ));

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : d;
  endfunction

  clkdiv_state_t    state_q, state_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             active_q, active_d;
  logic             wrap;
  logic             handshake;
  logic [DIV_W-1:0] cfg_clamped;

  assign handshake   = cfg_valid && cfg_ready_q;
  assign cfg_clamped = clamp_div(cfg_div);
  assign cfg_ready   = cfg_ready_q;
  assign active      = active_q;

  // Divisor changes only land at a wrap (or immediately when stopped), so the
  // output never shows a truncated phase.
  always_comb begin
    state_d    = state_q;
    div_cur_d  = div_cur_q;
    div_pend_d = div_pend_q;
    case (state_q)
      STOPPED: begin
        if (handshake) begin
          div_cur_d = cfg_clamped;
        end
        if (en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (wrap && !en) begin
          state_d = STOPPED;
          if (handshake) begin
            div_cur_d = cfg_clamped;
          end
        end else if (handshake) begin
          div_pend_d = cfg_clamped;
          state_d    = PEND;
        end
      end
      PEND: begin
        if (wrap) begin
          div_cur_d = div_pend_q;
          state_d   = en ? RUN : STOPPED;
        end
      end
      default: begin
        state_d = STOPPED;
      end
    endcase
    cfg_ready_d = (state_d != PEND);
    active_d    = (state_d != STOPPED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= STOPPED;
      div_cur_q   <= RESET_DIV;
      div_pend_q  <= RESET_DIV;
      cfg_ready_q <= 1'b1;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cur_q   <= div_cur_d;
      div_pend_q  <= div_pend_d;
      cfg_ready_q <= cfg_ready_d;
      active_q    <= active_d;
    end
  end

  clkdiv_core #(
    .DIV_W     (DIV_W),
    .RESET_DIV (RESET_DIV)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .counting (state_q != STOPPED),
    .run_next (state_d != STOPPED),
    .div_next (div_cur_d),
    .wrap     (wrap),
    .clk_out  (clk_out)
`ifdef CLKDIV_TICK_EN
    ,
    .tick     (tick)
`endif
  );

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Scoreboard bench for clkdiv_ctrl: directed steps push expected outputs,
// a monitor pops and compares them. Tick checks are active with CLKDIV_TICK_EN.
module tb_clkdiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] cfg_div;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        clk_out;
  logic        active;
`ifdef CLKDIV_TICK_EN
  logic        tick;
`endif

  typedef struct packed {
    logic clk_out;
    logic active;
    logic cfg_ready;
    logic tick;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  event  sample_ev;

  clkdiv_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_div   (cfg_div),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .active    (active)
`ifdef CLKDIV_TICK_EN
    ,
    .tick      (tick)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input string field,
                             input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%0b required=%0b at %0t", name, field, act, req, $time);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, or on demand for the
  // asynchronous reset check.
  initial begin : monitor
    exp_t  e;
    string n;
    forever begin
      @(negedge clk or sample_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checkOutput(n, "clk_out", clk_out, e.clk_out);
        checkOutput(n, "active", active, e.active);
        checkOutput(n, "cfg_ready", cfg_ready, e.cfg_ready);
`ifdef CLKDIV_TICK_EN
        checkOutput(n, "tick", tick, e.tick);
`endif
      end
    end
  end

  task automatic pushExp(input logic x_clk, input logic x_act, input logic x_rdy,
                         input logic x_tick, input string name);
    exp_t e;
    e.clk_out   = x_clk;
    e.active    = x_act;
    e.cfg_ready = x_rdy;
    e.tick      = x_tick;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // One clock step: inputs for the coming edge, outputs expected after it.
  task automatic applyStimulus(input logic e, input logic v, input logic [15:0] d,
                               input logic x_clk, input logic x_act, input logic x_rdy,
                               input logic x_tick, input string name);
    @(negedge clk);
    #1;
    en        = e;
    cfg_valid = v;
    cfg_div   = d;
    pushExp(x_clk, x_act, x_rdy, x_tick, name);
  endtask

  // One full running period with en high; the handshake (v,d) is offered on
  // its first step and cfg_valid=hold (divisor 9) on the remaining steps.
  task automatic runPeriod(input int hi, input int lo, input logic rdy,
                           input logic v, input logic [15:0] d, input logic hold,
                           input string name);
    for (int i = 0; i < hi + lo; i++) begin
      applyStimulus(1'b1, (i == 0) ? v : hold, (i == 0) ? d : 16'd9,
                    (i < hi), 1'b1, rdy, (i == hi + lo - 1), name);
    end
  endtask

  task automatic resetCheck(input string name);
    @(negedge clk);
    #1;
    reset     = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    #1;
    pushExp(1'b0, 1'b0, 1'b1, 1'b0, name);
    ->sample_ev;
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : stimulus
    reset     = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 16'd0;
    repeat (2) @(negedge clk);
    resetCheck("reset_init");

    // Default divisor 2 from start-up.
    for (int p = 0; p < 3; p++) runPeriod(1, 1, 1'b1, 1'b0, 16'd0, 1'b0, "div2");

    // Divisor 5 accepted on a wrap; a held cfg_valid during PEND is ignored.
    runPeriod(1, 1, 1'b0, 1'b1, 16'd5, 1'b1, "hs5_pend");
    for (int p = 0; p < 2; p++) runPeriod(3, 2, 1'b1, 1'b0, 16'd0, 1'b0, "div5");

    // Divisors 0 and 1 clamp to 2.
    runPeriod(3, 2, 1'b0, 1'b1, 16'd0, 1'b0, "clamp0_pend");
    runPeriod(1, 1, 1'b1, 1'b0, 16'd0, 1'b0, "clamp0_div2");
    runPeriod(1, 1, 1'b0, 1'b1, 16'd1, 1'b0, "clamp1_pend");
    for (int p = 0; p < 2; p++) runPeriod(1, 1, 1'b1, 1'b0, 16'd0, 1'b0, "clamp1_div2");

    // Divisor 6, then en dropped on the second cycle of a period.
    runPeriod(1, 1, 1'b0, 1'b1, 16'd6, 1'b0, "hs6_pend");
    runPeriod(3, 3, 1'b1, 1'b0, 16'd0, 1'b0, "div6");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, "div6_c1");
    applyStimulus(0, 0, 0, 1, 1, 1, 0, "en_low_c2");
    applyStimulus(0, 0, 0, 1, 1, 1, 0, "en_low_c3");
    applyStimulus(0, 0, 0, 0, 1, 1, 0, "en_low_c4");
    applyStimulus(0, 0, 0, 0, 1, 1, 0, "en_low_c5");
    applyStimulus(0, 0, 0, 0, 1, 1, 1, "en_low_c6");
    applyStimulus(0, 0, 0, 0, 0, 1, 0, "stopped");
    applyStimulus(0, 0, 0, 0, 0, 1, 0, "stopped_hold");

    // Second run: en low briefly, restored before the wrap, no gap.
    applyStimulus(1, 0, 0, 1, 1, 1, 0, "rerun_c1");
    applyStimulus(0, 0, 0, 1, 1, 1, 0, "rerun_c2");
    applyStimulus(0, 0, 0, 1, 1, 1, 0, "rerun_c3");
    applyStimulus(1, 0, 0, 0, 1, 1, 0, "rerun_c4");
    applyStimulus(1, 0, 0, 0, 1, 1, 0, "rerun_c5");
    applyStimulus(1, 0, 0, 0, 1, 1, 1, "rerun_c6");
    runPeriod(3, 3, 1'b1, 1'b0, 16'd0, 1'b0, "rerun_no_gap");

    // Stop, load divisor 4 while stopped, then run.
    applyStimulus(0, 0, 0, 0, 0, 1, 0, "stop2");
    applyStimulus(0, 1, 4, 0, 0, 1, 0, "stopped_hs4");
    for (int p = 0; p < 2; p++) runPeriod(2, 2, 1'b1, 1'b0, 16'd0, 1'b0, "div4");

    // Reset while a divisor is pending.
    applyStimulus(1, 1, 7, 1, 1, 0, 0, "hs7_accept");
    applyStimulus(1, 0, 0, 1, 1, 0, 0, "pend7");
    resetCheck("reset_pend");
    for (int p = 0; p < 2; p++) runPeriod(1, 1, 1'b1, 1'b0, 16'd0, 1'b0, "post_reset_div2");
    applyStimulus(0, 0, 0, 0, 0, 1, 0, "stop3");

    // Maximum divisor 65535: high 32768, low 32767.
    applyStimulus(0, 1, 16'hFFFF, 0, 0, 1, 0, "stopped_hs65535");
    runPeriod(32768, 32767, 1'b1, 1'b0, 16'd0, 1'b0, "div65535");
    applyStimulus(0, 0, 0, 0, 0, 1, 0, "stop4");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
